seg7_anim_scan_ctrl: RTL and testbench
======================================

# seg7_anim_scan_ctrl

Multi-digit successor to the single-digit seven-segment animation top. Holds animation-select and speed state driven by debounced one-shot button pulses, advances a frame counter at the selected rate, renders one of four animations across `NUM_DIGITS` common-cathode digits, and time-multiplexes them onto one shared segment bus. Sits between the button debouncers and the `uo_out`/`uio_out` pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; range 1..8.
- `CNT_W`, 25: prescaler/compare width.
- `SPEED_INIT`, 10_000_000: compare value after reset (1 s at 10 MHz).
- `SPEED_STEP`, 1_000_000: compare change per speed pulse.
- `SPEED_MIN`, 1_000_000 / `SPEED_MAX`, 20_000_000: saturation limits on compare.
- `SCAN_DIV`, 10_000: clocks per digit in the scan (1 ms at 10 MHz).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inc_ani`, `dec_ani`, `inc_speed`, `dec_speed` in 1 each: one-cycle pulses from debouncers.
- `run` in 1: level; low freezes the frame counter.
- `seg_out` out 8: bit0=a … bit6=g, bit7=dp; active-high.
- `digit_en` out NUM_DIGITS: one-hot digit select, active-high.
- `frame` out 6: current frame index (debug, drives `uio_out`).
- `ani` out 2: current animation.
- `tick` out 1: one-cycle pulse on each frame advance.

## Operation
- Reset (all registers): `ani`=0, `frame`=0, compare=`SPEED_INIT`, prescaler=0, scan counter=0, digit index=0, `digit_en`=1, `seg_out`=0, `tick`=0.
- Animation select: `inc_ani` → `ani`+1 mod 4; else `dec_ani` → `ani`−1 mod 4 (inc wins if both). Any change clears `frame` and prescaler in the same edge.
- Speed: `inc_speed` → compare=min(compare+`SPEED_STEP`, `SPEED_MAX`); else `dec_speed` → compare=max(compare−`SPEED_STEP`, `SPEED_MIN`). Saturating, no wrap; inc wins if both.
- Prescaler: while `run`=1, if prescaler ≥ compare → prescaler=0, `tick`=1, frame advances; else prescaler+1. `run`=0 holds prescaler and frame; `tick`=0. The ≥ compare means lowering compare below the running count fires on the next cycle.
- Frame: `frame`+1, wrapping to 0 after LIMIT(ani): COUNT=15, CHASE=6·NUM_DIGITS−1, BLINK=1, BAR=NUM_DIGITS.
- Glyph for digit d:
  - ani 0 COUNT: hex glyph of (frame+d) mod 16. Table 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - ani 1 CHASE: if 6d ≤ frame ≤ 6d+5, the single segment bit (frame−6d) (a..f); else 00.
  - ani 2 BLINK: frame 0 → 00, frame 1 → 7F.
  - ani 3 BAR: d < frame → 40 (segment g); else 00.
- Scan: scan counter counts 0..`SCAN_DIV`−1; on wrap, digit index +1 mod NUM_DIGITS. `digit_en` = one-hot(index); `seg_out[6:0]` = glyph(index). Both registered together, so no ghosting.

## Timing
- Pulse inputs act on the edge that samples them; `ani`/compare update one cycle later.
- `tick` and `frame` update on the same edge; `seg_out` reflects a new frame one cycle after that.
- Digit dwell is exactly `SCAN_DIV` cycles; full refresh is NUM_DIGITS·`SCAN_DIV`.
- Frame period is compare+1 cycles.
- `rst_n` deassertion mid-frame or mid-scan restarts from the reset state; no partial state survives.

## Configuration
- `SEG7_ANIM_DP_EN` defined: `seg_out[7]` is a heartbeat. It toggles on every `tick`, is shown only while digit index = 0, and resets to 0.
- Not defined: `seg_out[7]` is tied to 0 and the heartbeat register is absent.

## Test plan
- Reset, with NUM_DIGITS=4, SPEED_INIT=10, SCAN_DIV=4, SPEED_STEP=2, SPEED_MIN=4, SPEED_MAX=16 → `digit_en`=0001, `seg_out`=3F. After 4 clocks `digit_en`=0010 and `seg_out`=06. First `tick` occurs 11 clocks after reset release.
- 10 `inc_speed` pulses → compare saturates at 16 (frame period 17). Then 10 `dec_speed` pulses → compare saturates at 4 (period 5). No wrap.
- `inc_ani` and `dec_ani` pulsed in the same cycle at ani=3 → ani=0, frame=0, prescaler=0. Single `dec_ani` at ani=0 → ani=3.
- CHASE with NUM_DIGITS=4 → frame 0..23. Digit 2 shows 01 at frame 12 and 20 at frame 17, blank otherwise. Frame wraps 23→0.
- With prescaler at 9, `dec_speed` drops compare to 8 → `tick` fires on the next cycle. `run`=0 for 50 cycles → `frame` and prescaler unchanged and `tick` stays 0.
- With `SEG7_ANIM_DP_EN` defined → `seg_out[7]` toggles each tick, only while `digit_en`=0001. Without it, `seg_out[7]` is always 0.

Source files
------------

// File: rtl/seg7_anim_scan_ctrl.sv
// Multi-digit seven-segment animation controller: button-driven animation/speed state,
// frame prescaler, per-digit glyph rendering and registered digit scan.
// Optional define SEG7_ANIM_DP_EN turns seg_out[7] into a tick heartbeat on digit 0.
module seg7_anim_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 25,
  parameter int SPEED_INIT = 10_000_000,
  parameter int SPEED_STEP = 1_000_000,
  parameter int SPEED_MIN  = 1_000_000,
  parameter int SPEED_MAX  = 20_000_000,
  parameter int SCAN_DIV   = 10_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_ani,
  input  logic                  dec_ani,
  input  logic                  inc_speed,
  input  logic                  dec_speed,
  input  logic                  run,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [5:0]            frame,
  output logic [1:0]            ani,
  output logic                  tick
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW1    = CNT_W + 1;

  localparam logic [CNT_W-1:0]  INIT_C    = CNT_W'(SPEED_INIT);
  localparam logic [CNT_W-1:0]  STEP_C    = CNT_W'(SPEED_STEP);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(SPEED_MIN);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(SPEED_MAX);
  localparam logic [CNT_W:0]    STEP_X    = CW1'(SPEED_STEP);
  localparam logic [CNT_W:0]    MIN_X     = CW1'(SPEED_MIN);
  localparam logic [CNT_W:0]    MAX_X     = CW1'(SPEED_MAX);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [5:0]        LIM_CHASE = 6'(6 * NUM_DIGITS - 1);
  localparam logic [5:0]        LIM_BAR   = 6'(NUM_DIGITS);

  logic [1:0]            ani_r, ani_s;
  logic                  ani_chg_s;
  logic [CNT_W-1:0]      cmp_r, cmp_s;
  logic [CNT_W:0]        sum_s;
  logic [CNT_W-1:0]      pre_r, pre_s;
  logic [5:0]            frame_r, frame_s, limit_s;
  logic                  tick_r, tick_s;
  logic [SCAN_W-1:0]     scan_r, scan_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [NUM_DIGITS-1:0] den_r, den_s;
  logic [7:0]            seg_r, seg_s;
  logic                  dp_s;

  function automatic logic [6:0] hex_f(input logic [3:0] v);
    case (v)
      4'h0: hex_f = 7'h3F;  4'h1: hex_f = 7'h06;  4'h2: hex_f = 7'h5B;  4'h3: hex_f = 7'h4F;
      4'h4: hex_f = 7'h66;  4'h5: hex_f = 7'h6D;  4'h6: hex_f = 7'h7D;  4'h7: hex_f = 7'h07;
      4'h8: hex_f = 7'h7F;  4'h9: hex_f = 7'h6F;  4'hA: hex_f = 7'h77;  4'hB: hex_f = 7'h7C;
      4'hC: hex_f = 7'h39;  4'hD: hex_f = 7'h5E;  4'hE: hex_f = 7'h79;  4'hF: hex_f = 7'h71;
      default: hex_f = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] glyph_f(input logic [1:0] a, input logic [5:0] f,
                                         input logic [IDX_W-1:0] d);
    logic [6:0] base;
    logic [6:0] off;
    logic [3:0] hex;
    base = 7'(d) * 7'd6;
    off  = {1'b0, f} - base;
    hex  = f[3:0] + 4'(d);
    case (a)
      2'd0:    glyph_f = hex_f(hex);
      2'd1:    glyph_f = (({1'b0, f} >= base) && (off <= 7'd5)) ? (7'd1 << off) : 7'h00;
      2'd2:    glyph_f = (f == 6'd0) ? 7'h00 : 7'h7F;
      2'd3:    glyph_f = (7'(d) < {1'b0, f}) ? 7'h40 : 7'h00;
      default: glyph_f = 7'h00;
    endcase
  endfunction

  // Animation select: increment has priority over decrement.
  always_comb begin
    ani_s     = ani_r;
    ani_chg_s = 1'b0;
    if (inc_ani) begin
      ani_s     = ani_r + 2'd1;
      ani_chg_s = 1'b1;
    end else if (dec_ani) begin
      ani_s     = ani_r - 2'd1;
      ani_chg_s = 1'b1;
    end else begin
      ani_s     = ani_r;
      ani_chg_s = 1'b0;
    end
  end

  // Saturating compare value; the extra sum bit keeps overflow out of the limit test.
  always_comb begin
    sum_s = {1'b0, cmp_r} + STEP_X;
    cmp_s = cmp_r;
    if (inc_speed) begin
      cmp_s = (sum_s > MAX_X) ? MAX_C : sum_s[CNT_W-1:0];
    end else if (dec_speed) begin
      cmp_s = ({1'b0, cmp_r} < (MIN_X + STEP_X)) ? MIN_C : (cmp_r - STEP_C);
    end else begin
      cmp_s = cmp_r;
    end
  end

  // Prescaler and frame advance; an animation change restarts the frame sequence.
  always_comb begin
    case (ani_r)
      2'd0:    limit_s = 6'd15;
      2'd1:    limit_s = LIM_CHASE;
      2'd2:    limit_s = 6'd1;
      2'd3:    limit_s = LIM_BAR;
      default: limit_s = 6'd0;
    endcase
    pre_s   = pre_r;
    frame_s = frame_r;
    tick_s  = 1'b0;
    if (ani_chg_s) begin
      pre_s   = {CNT_W{1'b0}};
      frame_s = 6'd0;
    end else if (run) begin
      if (pre_r >= cmp_r) begin
        pre_s   = {CNT_W{1'b0}};
        tick_s  = 1'b1;
        frame_s = (frame_r >= limit_s) ? 6'd0 : (frame_r + 6'd1);
      end else begin
        pre_s = pre_r + CNT_W'(1'b1);
      end
    end else begin
      pre_s   = pre_r;
      frame_s = frame_r;
    end
  end

  // Digit scan position.
  always_comb begin
    if (scan_r >= SCAN_LAST) begin
      scan_s = {SCAN_W{1'b0}};
      idx_s  = (idx_r >= IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1'b1));
    end else begin
      scan_s = scan_r + SCAN_W'(1'b1);
      idx_s  = idx_r;
    end
  end

`ifdef SEG7_ANIM_DP_EN
  logic hb_r;

  // Heartbeat toggles on every frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_r <= 1'b0;
    end else if (tick_s) begin
      hb_r <= ~hb_r;
    end else begin
      hb_r <= hb_r;
    end
  end

  assign dp_s = (idx_s == {IDX_W{1'b0}}) ? hb_r : 1'b0;
`else
  assign dp_s = 1'b0;
`endif

  // Digit select and segments come from the same index, so they change together.
  always_comb begin
    den_s = NUM_DIGITS'(1'b1) << idx_s;
    seg_s = {dp_s, glyph_f(ani_r, frame_r, idx_s)};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ani_r   <= 2'd0;
      cmp_r   <= INIT_C;
      pre_r   <= {CNT_W{1'b0}};
      frame_r <= 6'd0;
      tick_r  <= 1'b0;
      scan_r  <= {SCAN_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      den_r   <= NUM_DIGITS'(1'b1);
      seg_r   <= 8'h00;
    end else begin
      ani_r   <= ani_s;
      cmp_r   <= cmp_s;
      pre_r   <= pre_s;
      frame_r <= frame_s;
      tick_r  <= tick_s;
      scan_r  <= scan_s;
      idx_r   <= idx_s;
      den_r   <= den_s;
      seg_r   <= seg_s;
    end
  end

  assign seg_out  = seg_r;
  assign digit_en = den_r;
  assign frame    = frame_r;
  assign ani      = ani_r;
  assign tick     = tick_r;

endmodule

// File: tb/tb_seg7_anim_scan_ctrl.sv
// Self-checking bench for seg7_anim_scan_ctrl: table-driven animation-select vectors,
// hand sequences for timing corners, and random stimulus against a behavioural model.
module tb_seg7_anim_scan_ctrl;

  localparam int ND    = 4;
  localparam int SINIT = 10;
  localparam int STEP  = 2;
  localparam int SMIN  = 4;
  localparam int SMAX  = 16;
  localparam int SCAN  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inc_ani = 1'b0, dec_ani = 1'b0, inc_speed = 1'b0, dec_speed = 1'b0;
  logic          run = 1'b0;
  logic [7:0]    seg_out;
  logic [ND-1:0] digit_en;
  logic [5:0]    frame;
  logic [1:0]    ani;
  logic          tick;

  int checks = 0;
  int failures = 0;

  seg7_anim_scan_ctrl #(
    .NUM_DIGITS(ND), .CNT_W(8), .SPEED_INIT(SINIT), .SPEED_STEP(STEP),
    .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .SCAN_DIV(SCAN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc_ani(inc_ani), .dec_ani(dec_ani),
    .inc_speed(inc_speed), .dec_speed(dec_speed), .run(run),
    .seg_out(seg_out), .digit_en(digit_en), .frame(frame), .ani(ani), .tick(tick)
  );

  always #5 clk = ~clk;

  // Behavioural reference state
  int hex_tbl[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int m_ani, m_frame, m_cmp, m_pre, m_cyc, m_hb;
  logic [7:0]    e_seg;
  logic [ND-1:0] e_den;
  logic          e_tick;

  function automatic int ref_limit(int a);
    case (a)
      0:       return 15;
      1:       return 6 * ND - 1;
      2:       return 1;
      default: return ND;
    endcase
  endfunction

  function automatic logic [7:0] ref_glyph(int a, int f, int d);
    case (a)
      0:       return 8'(hex_tbl[(f + d) % 16]);
      1:       return (f >= 6 * d && f <= 6 * d + 5) ? 8'(1 << (f - 6 * d)) : 8'h00;
      2:       return (f == 0) ? 8'h00 : 8'h7F;
      default: return (d < f) ? 8'h40 : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ani = 0; m_frame = 0; m_cmp = SINIT; m_pre = 0; m_cyc = 0; m_hb = 0;
    e_seg = 8'h00; e_den = ND'(1); e_tick = 1'b0;
  endtask

  task automatic model_step();
    int pa, pf, ph, old_cmp, d;
    pa = m_ani; pf = m_frame; ph = m_hb; old_cmp = m_cmp;
    if (inc_ani) m_ani = (m_ani + 1) % 4;
    else if (dec_ani) m_ani = (m_ani + 3) % 4;
    if (inc_speed) m_cmp = (m_cmp + STEP > SMAX) ? SMAX : m_cmp + STEP;
    else if (dec_speed) m_cmp = (m_cmp - STEP < SMIN) ? SMIN : m_cmp - STEP;
    e_tick = 1'b0;
    if (inc_ani || dec_ani) begin
      m_frame = 0; m_pre = 0;
    end else if (run) begin
      if (m_pre >= old_cmp) begin
        m_pre = 0; e_tick = 1'b1; m_hb = m_hb ^ 1;
        m_frame = (m_frame == ref_limit(pa)) ? 0 : m_frame + 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    m_cyc = m_cyc + 1;
    d = (m_cyc / SCAN) % ND;
    e_den = ND'(1 << d);
    e_seg = ref_glyph(pa, pf, d);
`ifdef SEG7_ANIM_DP_EN
    if (d == 0) e_seg[7] = ph[0];
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("digit_en", 32'(digit_en), 32'(e_den));
    chk("frame", 32'(frame), 32'(m_frame));
    chk("ani", 32'(ani), 32'(m_ani));
    chk("tick", 32'(tick), 32'(e_tick));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulse(input logic ia, input logic da, input logic is, input logic ds);
    inc_ani = ia; dec_ani = da; inc_speed = is; dec_speed = ds;
    step();
    inc_ani = 1'b0; dec_ani = 1'b0; inc_speed = 1'b0; dec_speed = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    chk("rst_digit_en", 32'(digit_en), 32'(ND'(1)));
    chk("rst_seg_out", 32'(seg_out), 32'h0);
    chk("rst_frame_ani_tick", {24'h0, frame, ani}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_frame(input int target);
    int n = 0;
    while (frame !== 6'(target) && n < 600) begin step(); n++; end
    chk("wait_frame", 32'(frame), 32'(target));
  endtask

  task automatic measure_period(output int per);
    int n = 0;
    while (tick !== 1'b1 && n < 100) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 100);
    per = n;
  endtask

  task automatic seg_at_digit(input string name, input int d, input logic [7:0] exp);
    int n = 0;
    step();
    while (digit_en !== ND'(1 << d) && n < 2 * ND * SCAN) begin step(); n++; end
    chk(name, 32'(seg_out), 32'(exp));
  endtask

  typedef struct {
    logic       ia;
    logic       da;
    logic [1:0] exp_ani;
  } ani_vec_t;

  ani_vec_t ani_tbl[8];

  initial begin
    int n, per, f0, tcount;
    ani_tbl[0] = '{1'b0, 1'b1, 2'd3};
    ani_tbl[1] = '{1'b1, 1'b1, 2'd0};
    ani_tbl[2] = '{1'b1, 1'b0, 2'd1};
    ani_tbl[3] = '{1'b1, 1'b0, 2'd2};
    ani_tbl[4] = '{1'b0, 1'b1, 2'd1};
    ani_tbl[5] = '{1'b1, 1'b1, 2'd2};
    ani_tbl[6] = '{1'b0, 1'b0, 2'd2};
    ani_tbl[7] = '{1'b1, 1'b0, 2'd3};

    // Reset state, first glyphs, first tick latency
    model_reset();
    do_reset();
    chk("post_rst_digit_en", 32'(digit_en), 32'h1);
    run = 1'b1;
    step();
    chk("first_seg", 32'(seg_out), 32'h3F);
    step(); step(); step();
    chk("digit1_en", 32'(digit_en), 32'h2);
    chk("digit1_seg", 32'(seg_out), 32'h06);
    n = 4;
    while (tick !== 1'b1 && n < 40) begin step(); n++; end
    chk("first_tick_clocks", 32'(n), 32'd11);

    // Speed saturation both ways
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    measure_period(per);
    chk("period_max", 32'(per), 32'd17);
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    measure_period(per);
    chk("period_min", 32'(per), 32'd5);

    // Animation select vectors
    for (int i = 0; i < 8; i++) begin
      pulse(ani_tbl[i].ia, ani_tbl[i].da, 1'b0, 1'b0);
      chk("tbl_ani", 32'(ani), 32'(ani_tbl[i].exp_ani));
      if (ani_tbl[i].ia || ani_tbl[i].da) chk("tbl_frame_clr", 32'(frame), 32'h0);
    end

    // Lowering compare below the running count fires on the next cycle
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) step();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("no_tick_yet", 32'(tick), 32'h0);
    step();
    chk("early_tick", 32'(tick), 32'h1);

    // run=0 freezes frame and prescaler
    for (int i = 0; i < 7; i++) step();
    run = 1'b0;
    f0 = int'(frame);
    tcount = 0;
    for (int i = 0; i < 50; i++) begin step(); if (tick === 1'b1) tcount++; end
    chk("hold_frame", 32'(frame), 32'(f0));
    chk("hold_ticks", 32'(tcount), 32'h0);
    run = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // CHASE rendering on digit 2 and frame wrap
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    wait_frame(12);
    run = 1'b0;
    seg_at_digit("chase_f12_d2", 2, 8'h01);
    run = 1'b1;
    wait_frame(17);
    run = 1'b0;
    seg_at_digit("chase_f17_d2", 2, 8'h20);
    seg_at_digit("chase_f17_d0", 0, 8'h00);
    run = 1'b1;
    wait_frame(23);
    n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 40);
    chk("chase_wrap", 32'(frame), 32'h0);

    // Random stimulus against the model, with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      run = ($urandom_range(0, 9) != 0);
      inc_ani   = ($urandom_range(0, 59) == 0);
      dec_ani   = ($urandom_range(0, 59) == 0);
      inc_speed = ($urandom_range(0, 29) == 0);
      dec_speed = ($urandom_range(0, 29) == 0);
      step();
    end
    inc_ani = 1'b0; dec_ani = 1'b0; inc_speed = 1'b0; dec_speed = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
